// File: rtl/dm_load_unit.sv
// Load unit: issues one word-aligned data RAM read per request, extracts and
// extends the byte/halfword/word, and returns it with its tag and an error code.
//
// state  | meaning
// IDLE   | ready for a request, no memory access
// WAIT   | read strobe high, waiting for rvalid or timeout
// RESP   | response held on rsp_* until rsp_ready
module dm_load_unit #(
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      m_data_addr,
  output logic             m_data_rd,
  input  logic             m_data_rvalid,
  input  logic [31:0]      m_data_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [1:0]       rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  // Last WAIT cycle index; WAIT lasts at most TIMEOUT_CYC cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [2:0]         op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic [1:0]         err_q, err_d;
  logic [31:0]        ext_data;
  logic [15:0]        half_sel;
  logic [7:0]         byte_sel;
  logic               req_illegal, req_misaligned;

  always_comb begin
    half_sel = addr_q[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    byte_sel = m_data_rdata[7:0];
    case (addr_q[1:0])
      2'b00:   byte_sel = m_data_rdata[7:0];
      2'b01:   byte_sel = m_data_rdata[15:8];
      2'b10:   byte_sel = m_data_rdata[23:16];
      default: byte_sel = m_data_rdata[31:24];
    endcase
    ext_data = m_data_rdata;
    case (op_q)
      OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext_data = {16'h0000, half_sel};
      OP_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext_data = {24'h000000, byte_sel};
      default: ext_data = m_data_rdata;
    endcase
  end

  assign req_illegal    = (req_op > OP_LBU);
  assign req_misaligned = ((req_op == OP_LW) && (req_addr[1:0] != 2'b00)) ||
                          (((req_op == OP_LH) || (req_op == OP_LHU)) && req_addr[0]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          op_d   = req_op;
          tag_d  = req_tag;
          data_d = 32'h0;
          cnt_d  = 8'h00;
          if (req_illegal) begin
            err_d   = ERR_ILL;
            state_d = S_RESP;
          end else if (req_misaligned) begin
            err_d   = ERR_MIS;
            state_d = S_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // rvalid on the final WAIT cycle still counts as a good read
        if (m_data_rvalid) begin
          data_d  = ext_data;
          err_d   = ERR_OK;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = 32'h0;
          err_d   = ERR_TO;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      op_q    <= 3'b000;
      tag_q   <= '0;
      cnt_q   <= 8'h00;
      data_q  <= 32'h0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign m_data_rd   = (state_q == S_WAIT);
  assign m_data_addr = m_data_rd ? {addr_q[31:2], 2'b00} : 32'h0;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_data    = rsp_valid ? data_q : 32'h0;
  assign rsp_tag     = rsp_valid ? tag_q : '0;
  assign rsp_err     = rsp_valid ? err_q : 2'b00;
  assign busy        = (state_q != S_IDLE);

endmodule
